icache_direct_mapped: RTL

- Parametrised direct-mapped instruction cache between the issue/fetch stage and the memory adaptor.
- Replaces the single-entry fetch path with NUM_LINES one-word lines.
- Adds a miss FSM with a request/accept/done handshake, whole-cache invalidation (fence.i) and pipeline-flush abort.

---
 rtl/icache_direct_mapped.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache, NUM_LINES one-word lines, miss FSM with abort/invalidate; ICACHE_STATS_EN adds hit/miss counters.
// Hit latency 1 cycle; one miss outstanding, busy holds off new lookups, rdy_in low freezes everything.
module icache_direct_mapped #(
  parameter int INDEX_W = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic        invalidate_all,
  input  logic        is_reading,
  input  logic [31:0] read_addr,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  output logic [31:0] read_data,
  output logic        is_ready,
  output logic        busy,
  output logic        request_ins_from_memory_adaptor,
  output logic [31:0] insaddr_to_be_fetched_from_memory_adaptor,
  input  logic        insfetch_task_accepted,
  input  logic [31:0] ins_fetched_from_memory_adaptor,
  input  logic        ins_fetch_done
);

  localparam int TAG_W     = 30 - INDEX_W;
  localparam int NUM_LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e                 state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic                   req_q, req_d;
  logic [31:0]            req_addr_q, req_addr_d;
  logic                   busy_q, busy_d;
  logic                   abort_q, abort_d;
  logic                   ready_q, ready_d;
  logic [31:0]            rdata_q, rdata_d;

  logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
  logic [31:0]            data_mem [NUM_LINES];

  logic [INDEX_W-1:0]     rd_idx;
  logic [TAG_W-1:0]       rd_tag;
  logic [INDEX_W-1:0]     fill_idx;
  logic [TAG_W-1:0]       fill_tag;
  logic                   lookup_vld;
  logic                   lookup_hit;
  logic                   fill_en;
  logic                   unused_addr_bits;

  assign rd_idx           = read_addr[INDEX_W+1:2];
  assign rd_tag           = read_addr[31:INDEX_W+2];
  assign fill_idx         = req_addr_q[INDEX_W+1:2];
  assign fill_tag         = req_addr_q[31:INDEX_W+2];
  assign unused_addr_bits = ^read_addr[1:0];

  assign lookup_vld = rdy_in && (state_q == S_IDLE) && is_reading;
  // A lookup racing a fence.i must not return a line that is being invalidated.
  assign lookup_hit = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag) && !invalidate_all;
  assign fill_en    = rdy_in && (state_q == S_WAIT) && ins_fetch_done;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    req_d      = req_q;
    req_addr_d = req_addr_q;
    busy_d     = busy_q;
    abort_d    = abort_q;
    ready_d    = ready_q;
    rdata_d    = rdata_q;
    if (rdy_in) begin
      ready_d = 1'b0;
      // Clear takes priority over a refill landing in the same cycle.
      if (invalidate_all) begin
        valid_d = '0;
      end else if (fill_en) begin
        valid_d[fill_idx] = 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (is_reading) begin
            if (lookup_hit) begin
              ready_d = !flush_pipline;
              rdata_d = data_mem[rd_idx];
            end else if (!flush_pipline) begin
              state_d    = S_REQ;
              req_d      = 1'b1;
              req_addr_d = {read_addr[31:2], 2'b00};
              busy_d     = 1'b1;
              abort_d    = 1'b0;
            end
          end
        end
        S_REQ: begin
          if (flush_pipline) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            busy_d  = 1'b0;
          end else if (insfetch_task_accepted) begin
            state_d = S_WAIT;
            req_d   = 1'b0;
          end
        end
        S_WAIT: begin
          if (flush_pipline) begin
            abort_d = 1'b1;
          end
          if (ins_fetch_done) begin
            ready_d = !(abort_q || flush_pipline);
            rdata_d = ins_fetched_from_memory_adaptor;
            state_d = S_IDLE;
            busy_d  = 1'b0;
            abort_d = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      req_q      <= 1'b0;
      req_addr_q <= '0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
      req_addr_q <= req_addr_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
    end
  end

  // Line storage needs no reset: valid_q guards every read.
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= ins_fetched_from_memory_adaptor;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (lookup_vld) begin
      if (lookup_hit) begin
        hit_count_d = hit_count_q + 32'd1;
      end else begin
        miss_count_d = miss_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

  // The flush also kills a hit pulse that is being presented this cycle.
  assign is_ready                                  = ready_q && !flush_pipline;
  assign read_data                                 = rdata_q;
  assign busy                                      = busy_q;
  assign request_ins_from_memory_adaptor           = req_q;
  assign insaddr_to_be_fetched_from_memory_adaptor = req_addr_q;

endmodule
